// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter onto a single-port RAM, with a wait
// timeout, alternating grants and an optional fetch buffer (IFETCH_BUF_EN).
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  state_e      last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic        buf_hit;
  logic [31:0] buf_word;
  logic        d_req, i_req;
  logic        ram_dhit, ram_ihit;

`ifdef IFETCH_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_word_q, buf_word_d;

  assign buf_hit  = iREN & buf_valid_q & (iaddr == buf_addr_q);
  assign buf_word = buf_word_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_word_d  = buf_word_q;
    if (ram_ihit) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = iaddr;
      buf_word_d  = ram_load;
    end else if (ram_dhit && dWEN && (daddr == buf_addr_q)) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_word_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_word_q  <= buf_word_d;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  // A fetch served by the buffer never competes for the RAM.
  assign d_req = dREN | dWEN;
  assign i_req = iREN & ~buf_hit;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    err_d        = err_q;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_addr     = '0;
    ram_store    = '0;
    ram_dhit     = 1'b0;
    ram_ihit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && last_grant_q == DATA)) begin
          state_d = DATA;
          addr_d  = daddr;
          cnt_d   = '0;
        end else if (i_req) begin
          state_d = INSTR;
          addr_d  = iaddr;
          cnt_d   = '0;
        end
      end
      DATA: begin
        ram_ren   = dREN & ~dWEN;
        ram_wen   = dWEN;
        ram_addr  = daddr;
        ram_store = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else if (daddr != addr_q) begin
          addr_d = daddr;
          cnt_d  = '0;
        end else if (ram_ready) begin
          ram_dhit     = 1'b1;
          state_d      = IDLE;
          last_grant_d = DATA;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      INSTR: begin
        // A buffer hit mid-transaction retires the fetch without the RAM.
        ram_ren  = ~buf_hit;
        ram_addr = buf_hit ? '0 : iaddr;
        if (!i_req) begin
          state_d = IDLE;
        end else if (iaddr != addr_q) begin
          addr_d = iaddr;
          cnt_d  = '0;
        end else if (ram_ready) begin
          ram_ihit     = 1'b1;
          state_d      = IDLE;
          last_grant_d = INSTR;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
      cnt_q        <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
    end
  end

  assign dhit  = ram_dhit;
  assign dload = ram_dhit ? ram_load : '0;
  assign ihit  = ram_ihit | buf_hit;
  assign iload = buf_hit ? buf_word : (ram_ihit ? ram_load : '0);
  assign err   = err_q;

endmodule
